// File: rtl/fmem_stream_reader_if.sv
// Valid/ready coefficient stream between the ROM reader and the MAC stage.
// The master drives data/valid/last, the slave drives ready.
interface fmem_stream_reader_if #(
    parameter int WIDTH = 20
);
    logic signed [WIDTH-1:0] data;
    logic                    valid;
    logic                    ready;
    logic                    last;

    modport master (
        output data,
        output valid,
        output last,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  last,
        output ready
    );
endinterface

// File: rtl/fmem_stream_reader.sv
// Read-side sequencer for the filter-coefficient ROM.
// Walks addresses 0..DEPTH-1 after a start pulse and hides the ROM's one-cycle
// read latency behind a 2-entry output FIFO. A read is only issued when the
// FIFO is guaranteed to have room for it, so words are never dropped.
// Optional build macro FMEM_WRAP_EN: the address wraps after DEPTH-1 and
// streaming repeats until the stop input ends it after the current pass.
module fmem_stream_reader #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 13,
    parameter int AW    = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [AW-1:0]           rom_addr,
    input  logic signed [WIDTH-1:0] rom_data,
    fmem_stream_reader_if.master    m
`ifdef FMEM_WRAP_EN
    ,
    input  logic                    stop
`endif
);

    localparam logic [1:0]    S_IDLE    = 2'd0;
    localparam logic [1:0]    S_FETCH   = 2'd1;
    localparam logic [1:0]    S_DRAIN   = 2'd2;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

    logic [1:0]              state;
    logic [1:0]              occ;
    logic                    rd_ptr;
    logic                    wr_ptr;
    logic                    vld_p1;
    logic                    last_p1;
    logic                    done_r;
    logic signed [WIDTH-1:0] buf_data [2];
    logic                    buf_last [2];
`ifdef FMEM_WRAP_EN
    logic                    stop_seen;
`endif

    logic                    accept;
    logic                    out_valid;
    logic                    pop;
    logic                    push;
    logic                    at_last;
    logic                    issue;
    logic                    end_of_pass;
    logic                    finish_fetch;
    logic [2:0]              demand;
    logic [AW-1:0]           addr_next;

    assign accept    = start && (state == S_IDLE);
    assign out_valid = (occ != 2'd0);
    assign pop       = out_valid && m.ready;
    assign push      = vld_p1;
    assign at_last   = (rom_addr == LAST_ADDR);

    // Words already buffered plus the one still in the ROM pipe must leave a
    // free slot (after this cycle's pop) for the read being issued now.
    assign demand      = {1'b0, occ} + {2'b00, vld_p1};
    assign issue       = (state == S_FETCH) && (demand < (3'd2 + {2'b00, pop}));
    assign end_of_pass = issue && at_last;

`ifdef FMEM_WRAP_EN
    assign finish_fetch = end_of_pass && (stop_seen || stop);
    assign addr_next    = at_last ? '0 : rom_addr + ADDR_ONE;
`else
    assign finish_fetch = end_of_pass;
    assign addr_next    = at_last ? rom_addr : rom_addr + ADDR_ONE;
`endif

    // Sequencer, address counter, ROM-latency tracker and FIFO bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            rom_addr  <= '0;
            occ       <= 2'd0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            vld_p1    <= 1'b0;
            last_p1   <= 1'b0;
            done_r    <= 1'b0;
`ifdef FMEM_WRAP_EN
            stop_seen <= 1'b0;
`endif
        end else begin
            done_r  <= 1'b0;
            vld_p1  <= issue;
            last_p1 <= end_of_pass;

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state     <= S_FETCH;
                        rom_addr  <= '0;
`ifdef FMEM_WRAP_EN
                        stop_seen <= 1'b0;
`endif
                    end
                end
                S_FETCH: begin
`ifdef FMEM_WRAP_EN
                    if (stop) begin
                        stop_seen <= 1'b1;
                    end
`endif
                    if (issue) begin
                        rom_addr <= addr_next;
                    end
                    if (finish_fetch) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pop && buf_last[rd_ptr]) begin
                        state  <= S_IDLE;
                        done_r <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // FIFO storage: capture the ROM word one cycle after its read was issued.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_data[wr_ptr] <= rom_data;
            buf_last[wr_ptr] <= last_p1;
        end
    end

    assign m.valid = out_valid;
    assign m.data  = out_valid ? buf_data[rd_ptr] : '0;
    assign m.last  = out_valid && buf_last[rd_ptr];
    assign busy    = (state != S_IDLE) || done_r;
    assign done    = done_r;

endmodule

// File: doc/fmem_stream_reader.md
# fmem_stream_reader

Read-side sequencer for the filter-coefficient ROM (`fmem_ROM`) in the generated 1-D CNN datapath. On a start pulse it walks ROM addresses 0..DEPTH-1 and absorbs the ROM's one-cycle registered read latency. It delivers each coefficient, in address order, on a valid/ready stream to the MAC stage. A 2-entry output buffer with credit-based issue gives full throughput under back-pressure and never drops or duplicates a word.

## Interface
Parameters:
- `WIDTH`, 20: coefficient width in bits; matches ROM output `z`.
- `DEPTH`, 13: number of coefficients; valid ROM addresses are 0..DEPTH-1.
- `AW`, 4: address width; DEPTH ≤ 2^AW.

Ports:
- `clk`  in  1: single clock; all logic is on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle request to stream the full coefficient set; ignored while `busy`=1.
- `busy`  out  1: high from the cycle after an accepted `start` through the `done` cycle.
- `done`  out  1: one-cycle pulse after the last word's handshake.
- `rom_addr`  out  AW: registered address to the ROM `addr` input.
- `rom_data`  in  WIDTH: ROM `z`; holds data for the `rom_addr` value of the previous cycle.
- `m_data`  out  WIDTH: coefficient output.
- `m_valid`  out  1: `m_data` is valid.
- `m_ready`  in  1: consumer accepts; transfer occurs when `m_valid`&`m_ready`.
- `m_last`  out  1: qualifies the word with address DEPTH-1.
- `stop`  in  1: present only with `FMEM_WRAP_EN`; see Configuration.

## Operation
- States:
  - IDLE → FETCH on `start`.
  - FETCH → DRAIN when the last address has been issued.
  - DRAIN → IDLE on the cycle the `m_last` word transfers.
  - `done` pulses in that transfer cycle +1, which is the first IDLE cycle.
- Issue rule: in FETCH, a read is issued in cycle c when `occ + inflight - pop < 2`.
  - `occ` is the buffer occupancy (0..2).
  - `inflight` is 1 if a read was issued in cycle c-1.
  - `pop` is the handshake in cycle c.
- On an issue, `rom_addr` advances to the next address at the end of cycle c.
- `rom_addr` may hold its value between issues; the ROM has no enable, so repeated reads are harmless.
- The data for the read issued in cycle c is written into the buffer at the end of cycle c+1.
- The buffer is a 2-entry FIFO: push and pop in the same cycle are both performed, and occupancy is unchanged.
  - Overflow is impossible by the issue rule. Verification asserts `occ ≤ 2`.
- `m_valid` = (`occ`>0). `m_data`/`m_last` come from the head entry. `m_last` is stored with each entry as (issued address == DEPTH-1).
- Address counter width is AW. It saturates at DEPTH-1 in single-pass mode and never reaches an out-of-range address.
- `start` while `busy`=1 is ignored, with no state change.
- `start` arriving in the same cycle as `done` is accepted.
- Asynchronous reset mid-stream aborts the stream:
  - The buffer is emptied.
  - The in-flight read is discarded.
  - The state returns to IDLE.

## Timing
- Reset values: `busy`=0, `done`=0, `m_valid`=0, `m_last`=0, `m_data`=0, `rom_addr`=0, state IDLE, `occ`=0.
- Start latency:
  - `start` high in cycle 0.
  - FETCH in cycle 1, with address 0 sampled by the ROM at the end of cycle 1.
  - Word 0 is pushed at the end of cycle 2.
  - `m_valid`=1 in cycle 3.
- With `m_ready` held high, one word transfers per cycle in cycles 3..DEPTH+2.
  - The `m_last` transfer is in cycle DEPTH+2 (15 for DEPTH=13).
  - `done` pulses in cycle DEPTH+3, and `busy` falls after it.
- Under back-pressure, `m_data`, `m_valid` and `m_last` stay stable until the transfer.
- Once `m_ready` is deasserted, no more than 2 words are buffered.

## Configuration
- `FMEM_WRAP_EN` defined:
  - After address DEPTH-1, the counter wraps to 0 and streaming continues indefinitely.
  - `m_last` still marks every DEPTH-1 word.
  - The `stop` port exists. It is sampled in FETCH: once `stop` is seen, the issue of further passes ceases after the pass currently being fetched.
  - The controller then drains to the next `m_last` transfer and pulses `done`.
- `FMEM_WRAP_EN` undefined:
  - Single pass of DEPTH words, then `done`.
  - No `stop` port.

## Test plan
- Reset, then `start` with `m_ready`=1 → 13 words in cycles 3..15 matching ROM contents (406, 22, -125, ... -288); `m_last` only on -288; `done` in cycle 16.
- `m_ready` toggling 1,0,0,1 repeatedly → same 13-word sequence, no drop/duplicate, outputs stable while stalled, `occ` ≤ 2.
- `m_ready`=0 for 20 cycles after `start` → exactly 2 words buffered, `rom_addr` ≤ 2; release gives the remaining sequence intact.
- `start` pulsed mid-stream, and again in the `done` cycle → first ignored; second starts a new pass with word 0 (406) 3 cycles later.
- `reset_n` low at word 6 → all outputs return to reset values immediately; a subsequent `start` yields a full, correct 13-word pass.
- `FMEM_WRAP_EN`: `stop` asserted during the second pass → stream 406 … -288, 406 … -288 (26 words), then `done`; no third pass.
